// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential 2-bit-digit multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam int unsigned DefWidth = 8;

    // Number of 2-bit digits in one operand.
    function automatic int unsigned digit_count(input int unsigned width);
        return width / 2;
    endfunction

endpackage

// File: rtl/mul_2bit.sv
// Combinational 2x2-bit unsigned multiplier; the single digit-product unit.
module mul_2bit (
    input  logic [1:0] i_a,
    input  logic [1:0] i_b,
    output logic [3:0] o_p
);

    assign o_p = {2'b00, i_a} * {2'b00, i_b};

endmodule

// File: rtl/mul_seq_8bit.sv
// Sequential unsigned multiplier: accumulates one 2-bit digit-pair product per cycle
// with a valid/ready handshake on both the operand and product sides.
module mul_seq_8bit
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned Digits  = digit_count(WIDTH);
    localparam int unsigned Pairs   = Digits * Digits;
    localparam int unsigned CntW    = $clog2(Pairs);
    localparam int unsigned ProdW   = 2 * WIDTH;
    localparam logic [CntW-1:0] LastCnt = CntW'(Pairs - 1);

    state_e             r_state, w_state_d;
    logic [WIDTH-1:0]   r_a, r_b, w_a_d, w_b_d;
    logic [ProdW-1:0]   r_acc, w_acc_d;
    logic [CntW-1:0]    r_cnt, w_cnt_d;

    int unsigned        w_i, w_j;
    logic [1:0]         w_a_dig, w_b_dig;
    logic [3:0]         w_pp;
    logic [ProdW-1:0]   w_term;

    // Counter is j-major: the a-digit index i runs fastest.
    assign w_i     = 32'(r_cnt) % Digits;
    assign w_j     = 32'(r_cnt) / Digits;
    assign w_a_dig = 2'(r_a >> (2 * w_i));
    assign w_b_dig = 2'(r_b >> (2 * w_j));
    assign w_term  = ProdW'(w_pp) << (2 * (w_i + w_j));

    mul_2bit u_mul_2bit (
        .i_a (w_a_dig),
        .i_b (w_b_dig),
        .o_p (w_pp)
    );

    always_comb begin
        w_state_d = r_state;
        w_a_d     = r_a;
        w_b_d     = r_b;
        w_acc_d   = r_acc;
        w_cnt_d   = r_cnt;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_a_d     = a;
                    w_b_d     = b;
                    w_acc_d   = '0;
                    w_cnt_d   = '0;
                    w_state_d = StRun;
                end
            end
            StRun: begin
                w_acc_d = r_acc + w_term;
                if (r_cnt == LastCnt) begin
                    w_cnt_d   = '0;
                    w_state_d = StDone;
                end else begin
                    w_cnt_d = r_cnt + CntW'(1);
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_a     <= w_a_d;
            r_b     <= w_b_d;
            r_acc   <= w_acc_d;
            r_cnt   <= w_cnt_d;
        end
    end

    assign product = r_acc;

endmodule

// File: tb/tb_mul_seq_8bit.sv
// Self-checking bench for mul_seq_8bit: vector table, scoreboard queue and corner sequences.
module tb_mul_seq_8bit;

    localparam int unsigned Lat    = 16;
    localparam int unsigned Period = 18;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;

    int n_vec;
    int n_err;
    logic [15:0] sb[$];

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        int          hold;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[8];

    mul_seq_8bit #(.WIDTH(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One full transaction; hold > 0 keeps out_ready low that many DONE cycles
    // while scrambling the operand inputs.
    task automatic do_op(input logic [7:0] va, input logic [7:0] vb, input int hold,
                         input logic [15:0] exp);
        int n;
        logic [15:0] want;
        n = 0;
        while (!in_ready && n < 40) begin
            step();
            n++;
        end
        check("accept_ready", {31'b0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        a         = va;
        b         = vb;
        out_ready = (hold == 0);
        sb.push_back(exp);
        step();
        in_valid = 1'b0;
        a        = 8'($urandom);
        b        = 8'($urandom);
        check("run_in_ready", {31'b0, in_ready}, 32'd0);
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        check("latency", n, Lat);
        if (!out_valid) begin
            void'(sb.pop_front());
            return;
        end
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'($urandom);
            a        = 8'($urandom);
            b        = 8'($urandom);
            step();
            check("hold_product", {16'b0, product}, {16'b0, exp});
            check("hold_in_ready", {31'b0, in_ready}, 32'd0);
            check("hold_out_valid", {31'b0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        want = sb.pop_front();
        check("product", {16'b0, product}, {16'b0, want});
        out_ready = 1'b1;
        step();
        check("post_out_valid", {31'b0, out_valid}, 32'd0);
        check("post_in_ready", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        int n;
        int accepts;
        int results;
        int last_acc;
        int cyc;
        logic seen_stale;
        logic [15:0] want;

        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;

        vecs[0] = '{a: 8'd3,   b: 8'd3,   hold: 0, exp: 16'd9};
        vecs[1] = '{a: 8'd255, b: 8'd255, hold: 0, exp: 16'hFE01};
        vecs[2] = '{a: 8'd170, b: 8'd85,  hold: 0, exp: 16'd14450};
        vecs[3] = '{a: 8'd0,   b: 8'd200, hold: 0, exp: 16'd0};
        vecs[4] = '{a: 8'd12,  b: 8'd11,  hold: 5, exp: 16'd132};
        vecs[5] = '{a: 8'd1,   b: 8'd1,   hold: 1, exp: 16'd1};
        vecs[6] = '{a: 8'd255, b: 8'd0,   hold: 0, exp: 16'd0};
        vecs[7] = '{a: 8'd128, b: 8'd2,   hold: 2, exp: 16'd256};

        step();
        step();
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_product", {16'b0, product}, 32'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            do_op(vecs[v].a, vecs[v].b, vecs[v].hold, vecs[v].exp);
        end

        // Abort mid-run: reset after 8 RUN edges must drop everything at once.
        in_valid = 1'b1;
        a        = 8'd200;
        b        = 8'd100;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) step();
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_product", {16'b0, product}, 32'd0);
        check("abort_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        rst_n = 1'b1;
        seen_stale = 1'b0;
        for (int k = 0; k < 24; k++) begin
            if (out_valid) seen_stale = 1'b1;
            step();
        end
        check("abort_no_result", {31'b0, seen_stale}, 32'd0);
        do_op(8'd7, 8'd9, 0, 16'd63);

        // Back-to-back stream with in_valid always high.
        accepts  = 0;
        results  = 0;
        last_acc = -1;
        cyc      = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while ((accepts < 50 || results < 50) && cyc < 2000) begin
            a = 8'($urandom);
            b = 8'($urandom);
            if (accepts == 50) in_valid = 1'b0;
            if (in_ready && in_valid) begin
                if (last_acc >= 0) check("stream_spacing", cyc - last_acc, Period);
                last_acc = cyc;
                sb.push_back(16'(a) * 16'(b));
                accepts++;
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("stream_spurious", 32'd1, 32'd0);
                end else begin
                    want = sb.pop_front();
                    check("stream_product", {16'b0, product}, {16'b0, want});
                end
                results++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        check("stream_results", results, 50);
        check("stream_sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mul_seq_8bit.md
MUL_SEQ_8BIT -- requirements
Module: mul_seq_8bit

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL be even and at least 4.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operand pair a/b is presented.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  WIDTH  multiplicand, unsigned.
REQ-007 b  input  WIDTH  multiplier, unsigned.
REQ-008 out_valid  output  1  product is valid.
REQ-009 out_ready  input  1  downstream accepts product.
REQ-010 product  output  2*WIDTH  unsigned a*b.

Function
REQ-011 Block SHALL compute product by iterating over all (i,j) pairs of 2-bit digits, i over a and j over b, D=(WIDTH/2)^2 pairs (16 for WIDTH=8).
REQ-012 Per iteration, the 4-bit digit product a[2i+1:2i]*b[2j+1:2j] SHALL come from one mul_2bit instance, be zero-extended, shifted left 2*(i+j), and added to a 2*WIDTH accumulator; the sum SHALL never overflow.
REQ-013 FSM states IDLE, RUN, DONE; encoding is implementation choice.
REQ-014 IDLE: in_ready=1, out_valid=0; on edge with in_valid=1, SHALL latch a and b, clear accumulator, clear digit counter, go to RUN.
REQ-015 RUN: in_ready=0, out_valid=0; one digit pair per edge, order j-major (i fastest); on edge adding pair D-1 SHALL go to DONE.
REQ-016 Latency: out_valid SHALL rise exactly D edges after the accepting edge (16 for WIDTH=8), independent of operand values, including zero.
REQ-017 DONE: out_valid=1, in_ready=0, product SHALL be held stable until the edge with out_ready=1, then go to IDLE.
REQ-018 product SHALL show the accumulator at all times; its value is defined only while out_valid=1.
REQ-019 in_valid, a, b SHALL be ignored outside IDLE; operand changes after acceptance SHALL NOT affect the result.
REQ-020 No overlap: a new pair SHALL be accepted no earlier than the cycle after the product handshake (throughput one result per D+2 cycles).
REQ-021 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-022 rst_n=0 SHALL immediately force IDLE, in_ready=1, out_valid=0, product=0, digit counter=0, operand registers=0.
REQ-023 Reset during RUN or DONE SHALL abort the operation; no product for it SHALL ever be presented.
REQ-024 First accept after rst_n deasserts SHALL be possible on the first rising edge with rst_n=1 and in_valid=1.

Structure
REQ-025 Shared package mul_pkg SHALL hold the state enum typedef, default WIDTH constant and a digit-count constant/function (WIDTH/2).
REQ-026 Exactly one sub-module SHALL be used: mul_2bit, single instance, driven from registered operand digits selected by the digit counter.
REQ-027 Digit counter SHALL be log2(D) bits and wrap to 0 on the final pair.

Verification
REQ-028 a=3, b=3, in_valid one cycle, out_ready=1 -> out_valid rises 16 edges after accept, product=9, in_ready high the following cycle.
REQ-029 a=255, b=255 -> product=65025 (0xFE01); a=170, b=85 -> product=14450.
REQ-030 a=0, b=200 -> product=0 with latency still 16 edges.
REQ-031 a=12, b=11, out_ready low 5 cycles after out_valid, a/b/in_valid toggled meanwhile -> product stays 132, in_ready stays 0, accepted on first out_ready=1 edge.
REQ-032 rst_n pulsed low at RUN edge 8 of a=200,b=100 -> out_valid=0, product=0 immediately, no 20000 ever emitted; next a=7,b=9 -> 63.
REQ-033 in_valid held high with changing operands, out_ready=1, 50 random pairs -> each product matches a*b, one accept per D+2 cycles, zero lost or duplicated results.
